// File: rtl/line_merge_buffer_pkg.sv
// Shared types for the store merge path.
// Contents:
//   lc3b_word / lc3b_mem_wmask  : one CPU store word and its 2-bit byte mask
//   lc3b_line / lc3b_line_mask  : one 128-bit line and its 16-bit per-byte mask
//   lc3b_line_tag               : line address above the 4-bit byte offset
//   lmb_state_t                 : merge buffer FSM states
package lc3b_types;

  localparam int LINE_BITS   = 128;
  localparam int WORD_BITS   = 16;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int WORDS       = LINE_BITS / WORD_BITS;

  typedef logic [WORD_BITS-1:0]         lc3b_word;
  typedef logic [1:0]                   lc3b_mem_wmask;
  typedef logic [LINE_BITS-1:0]         lc3b_line;
  typedef logic [LINE_BITS/8-1:0]       lc3b_line_mask;
  typedef logic [15-OFFSET_BITS:0]      lc3b_line_tag;
  typedef logic [$clog2(WORDS)-1:0]     lc3b_word_offset;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } lmb_state_t;

endpackage

// File: rtl/line_merge_buffer_word_insert.sv
// word_insert: places one 16-bit store word into a 128-bit line.
// Inverse of the line-to-word select mux on the read path.
// Ports:
//   line, mask      : current line contents and dirty byte mask
//   offset          : word index within the line (address bits [3:1])
//   word, wmask     : store data and its byte enables (bit0 = low byte)
//   new_line        : line with the enabled bytes replaced
//   new_mask        : mask with the written bytes set
module word_insert
  import lc3b_types::*;
(
  input  lc3b_line        line,
  input  lc3b_line_mask   mask,
  input  lc3b_word_offset offset,
  input  lc3b_word        word,
  input  lc3b_mem_wmask   wmask,
  output lc3b_line        new_line,
  output lc3b_line_mask   new_mask
);

  always_comb begin
    new_line = line;
    new_mask = mask;
    for (int b = 0; b < LINE_BITS / 8; b++) begin
      // Byte b belongs to word b/2; its half within that word is b[0].
      if (b[3:1] == offset && wmask[b[0]]) begin
        new_line[b*8 +: 8] = b[0] ? word[15:8] : word[7:0];
        new_mask[b]        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/line_merge_buffer.sv
// line_merge_buffer: merges byte-masked 16-bit CPU stores into one 128-bit
// line buffer and drains it to physical memory with a per-byte enable.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   in_valid/in_ready        : store request handshake
//   in_addr/in_wdata         : store byte address (bit 0 ignored) and data
//   in_mem_byte_enable       : store byte mask (bit0 low byte, bit1 high byte)
//   flush                    : request a drain of the buffered line
//   idle                     : no dirty bytes buffered
//   pmem_write..byte_enable  : memory write port, held until pmem_resp
//   pmem_resp                : memory write complete
//   dbg_state                : current FSM state, for observation only
//
// Handshake: a store transfers on a rising edge where in_valid and in_ready
// are both high; in_valid/in_addr/in_wdata/in_mem_byte_enable must stay
// stable while in_valid is high and in_ready is low. in_ready depends
// combinationally on in_addr while collecting (tag compare).
module line_merge_buffer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  lc3b_word      in_addr,
  input  lc3b_word      in_wdata,
  input  lc3b_mem_wmask in_mem_byte_enable,
  input  logic          flush,
  output logic          idle,
  output logic          pmem_write,
  output lc3b_word      pmem_address,
  output lc3b_line      pmem_wdata,
  output lc3b_line_mask pmem_byte_enable,
  input  logic          pmem_resp,
  output lmb_state_t    dbg_state
);

  lmb_state_t    state_q, state_d;
  lc3b_line_tag  tag_q, tag_d;
  lc3b_line      line_q, line_d;
  lc3b_line_mask mask_q, mask_d;

  lc3b_line      ins_line;
  lc3b_line_mask ins_mask;
  lc3b_line_tag  in_tag;
  logic          tag_hit;

  assign in_tag  = in_addr[15:4];
  assign tag_hit = (in_tag == tag_q);

  // mask_q is zero whenever the FSM is in IDLE, so the same merge result
  // serves both the first store of a line and later same-tag stores.
  word_insert u_word_insert (
    .line     (line_q),
    .mask     (mask_q),
    .offset   (in_addr[3:1]),
    .word     (in_wdata),
    .wmask    (in_mem_byte_enable),
    .new_line (ins_line),
    .new_mask (ins_mask)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tag_q   <= '0;
      line_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    line_d     = line_q;
    mask_d     = mask_q;
    in_ready   = 1'b0;
    pmem_write = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // An all-zero byte enable completes the handshake but buffers nothing.
        if (in_valid && in_mem_byte_enable != 2'b00) begin
          tag_d   = in_tag;
          line_d  = ins_line;
          mask_d  = ins_mask;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        in_ready = !in_valid || tag_hit;
        if (in_valid && !tag_hit) begin
          // Foreign line: hold the request off and evict the current one.
          state_d = DRAIN;
        end else begin
          if (in_valid) begin
            line_d = ins_line;
            mask_d = ins_mask;
          end
          // Checked on the merged mask so a store that completes the line
          // (or arrives with flush) is included in this drain.
          if (flush || mask_d == '1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          mask_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle             = (state_q == IDLE);
  assign pmem_address     = {tag_q, 4'b0000};
  assign pmem_wdata       = line_q;
  assign pmem_byte_enable = mask_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_line_merge_buffer.sv
module tb_line_merge_buffer;
  import lc3b_types::*;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [15:0]   in_addr = '0;
  logic [15:0]   in_wdata = '0;
  logic [1:0]    in_mem_byte_enable = '0;
  logic          flush = 1'b0;
  logic          idle;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic [15:0]   pmem_byte_enable;
  logic          pmem_resp = 1'b0;
  lmb_state_t    dbg_state;

  always #5 clk = ~clk;

  line_merge_buffer dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_addr            (in_addr),
    .in_wdata           (in_wdata),
    .in_mem_byte_enable (in_mem_byte_enable),
    .flush              (flush),
    .idle               (idle),
    .pmem_write         (pmem_write),
    .pmem_address       (pmem_address),
    .pmem_wdata         (pmem_wdata),
    .pmem_byte_enable   (pmem_byte_enable),
    .pmem_resp          (pmem_resp),
    .dbg_state          (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // The buffered line as a byte array plus a dirty bit per byte.
  logic [7:0]   m_bytes [16];
  logic [15:0]  m_mask = '0;
  logic [11:0]  m_tag = '0;
  // Expected drains: {address[15:0], data[127:0], byte_enable[15:0]}.
  logic [159:0] exp_q[$];

  logic          resp_en = 1'b0;
  int            drain_count = 0;
  logic [127:0]  last_wdata;
  logic [15:0]   last_be;
  logic [15:0]   last_addr;

  task automatic model_reset();
    m_mask = '0;
    m_tag  = '0;
    exp_q.delete();
  endtask

  task automatic push_drain();
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = m_bytes[i];
    exp_q.push_back({m_tag, 4'b0000, d, m_mask});
    m_mask = '0;
  endtask

  task automatic apply_store(input logic [15:0] a, input logic [15:0] d,
                             input logic [1:0] be, input logic fl);
    logic was_empty;
    int   wi;
    was_empty = (m_mask == 16'h0);
    wi = int'(a[3:1]);
    if (was_empty && be != 2'b00) m_tag = a[15:4];
    if (!was_empty || be != 2'b00) begin
      if (be[0]) begin m_bytes[2*wi]   = d[7:0];  m_mask[2*wi]   = 1'b1; end
      if (be[1]) begin m_bytes[2*wi+1] = d[15:8]; m_mask[2*wi+1] = 1'b1; end
    end
    // A flush only counts once a line was already being collected.
    if ((!was_empty && fl) || m_mask == 16'hFFFF) push_drain();
  endtask

  // ---------------- driver tasks ----------------
  task automatic store(input logic [15:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic fl);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_addr = a; in_wdata = d;
    in_mem_byte_enable = be; flush = fl;
    #1;
    if (m_mask != 16'h0) begin
      checks++;
      if (in_ready !== (a[15:4] == m_tag)) begin
        errors++;
        $display("FAIL store_ready addr=%h got=%b want=%b", a, in_ready, (a[15:4] == m_tag));
      end
      if (a[15:4] != m_tag) push_drain();
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL store_timeout addr=%h in_ready=%b want=1", a, in_ready);
    end else begin
      apply_store(a, d, be, fl);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; in_mem_byte_enable = 2'b00;
  endtask

  task automatic flush_only();
    @(negedge clk);
    flush = 1'b1;
    if (m_mask != 16'h0) push_drain();
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_drains();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || idle !== 1'b1) && n < 300) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d idle=%b want pending=0 idle=1", exp_q.size(), idle);
    end
  endtask

  // ---------------- memory responder / scoreboard ----------------
  initial begin
    logic [159:0] e;
    logic [127:0] bm;
    int lat;
    forever begin
      @(negedge clk);
      if (resp_en && pmem_write === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_drain addr=%h be=%h want no write", pmem_address, pmem_byte_enable);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 16; i++) bm[i*8 +: 8] = {8{e[i]}};
          if (pmem_address !== e[159:144] || pmem_byte_enable !== e[15:0] ||
              (pmem_wdata & bm) !== (e[143:16] & bm)) begin
            errors++;
            $display("FAIL drain_data got addr=%h be=%h data=%h want addr=%h be=%h data=%h",
                     pmem_address, pmem_byte_enable, pmem_wdata & bm,
                     e[159:144], e[15:0], e[143:16] & bm);
          end
        end
        last_wdata = pmem_wdata; last_be = pmem_byte_enable; last_addr = pmem_address;
        drain_count++;
        lat = $urandom_range(0, 3);
        repeat (lat) begin
          @(negedge clk);
          checks++;
          if (pmem_write !== 1'b1) begin
            errors++;
            $display("FAIL write_held got=%b want=1", pmem_write);
          end
        end
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (idle !== 1'b1 || pmem_write !== 1'b0 || in_ready !== 1'b1 ||
        pmem_byte_enable !== 16'h0 || pmem_address !== 16'h0) begin
      errors++;
      $display("FAIL reset_state idle=%b wr=%b rdy=%b be=%h addr=%h want 1 0 1 0000 0000",
               idle, pmem_write, in_ready, pmem_byte_enable, pmem_address);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_flush();
    resp_en = 1'b0;
    store(16'h1002, 16'hBEEF, 2'b11, 1'b0);
    flush_only();
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h1000 ||
        pmem_wdata[31:16] !== 16'hBEEF || pmem_byte_enable !== 16'h000C || idle !== 1'b0) begin
      errors++;
      $display("FAIL flush_drain wr=%b addr=%h w1=%h be=%h idle=%b want 1 1000 beef 000c 0",
               pmem_write, pmem_address, pmem_wdata[31:16], pmem_byte_enable, idle);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pmem_write !== 1'b1) begin
        errors++;
        $display("FAIL flush_held got=%b want=1", pmem_write);
      end
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    checks++;
    if (pmem_write !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL flush_done wr=%b idle=%b want 0 1", pmem_write, idle);
    end
    model_reset();
  endtask

  task automatic test_full_line();
    logic ok;
    resp_en = 1'b1;
    for (int i = 0; i < 8; i++) store(16'h2000 + 16'(2 * i), 16'(i), 2'b11, 1'b0);
    wait_drains();
    ok = (last_be === 16'hFFFF) && (last_addr === 16'h2000);
    for (int i = 0; i < 8; i++) if (last_wdata[i*16 +: 16] !== 16'(i)) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_line addr=%h be=%h data=%h want 2000 ffff words 0..7",
               last_addr, last_be, last_wdata);
    end
  endtask

  task automatic test_tag_conflict();
    resp_en = 1'b0;
    store(16'h3000, 16'h1111, 2'b11, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_addr = 16'h3010; in_wdata = 16'h2222; in_mem_byte_enable = 2'b11;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_ready got=%b want=0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (pmem_write !== 1'b1 || pmem_address !== 16'h3000 || pmem_byte_enable !== 16'h0003 ||
        pmem_wdata[15:0] !== 16'h1111 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL conflict_drain wr=%b addr=%h be=%h w0=%h rdy=%b want 1 3000 0003 1111 0",
               pmem_write, pmem_address, pmem_byte_enable, pmem_wdata[15:0], in_ready);
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    checks++;
    if (pmem_write !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL conflict_release wr=%b rdy=%b want 0 1", pmem_write, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_mem_byte_enable = 2'b00;
    checks++;
    if (idle !== 1'b0 || pmem_address !== 16'h3010) begin
      errors++;
      $display("FAIL conflict_accept idle=%b addr=%h want 0 3010", idle, pmem_address);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (pmem_write !== 1'b1 || pmem_wdata[15:0] !== 16'h2222 || pmem_byte_enable !== 16'h0003) begin
      errors++;
      $display("FAIL conflict_second wr=%b w0=%h be=%h want 1 2222 0003",
               pmem_write, pmem_wdata[15:0], pmem_byte_enable);
    end
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    model_reset();
  endtask

  task automatic test_byte_merge();
    resp_en = 1'b1;
    store(16'h4004, 16'h00AA, 2'b01, 1'b0);
    store(16'h4004, 16'hBB00, 2'b10, 1'b0);
    flush_only();
    wait_drains();
    checks++;
    if (last_wdata[47:32] !== 16'hBBAA || last_be !== 16'h0030) begin
      errors++;
      $display("FAIL byte_merge w2=%h be=%h want bbaa 0030", last_wdata[47:32], last_be);
    end
  endtask

  task automatic test_reset_mid_drain();
    resp_en = 1'b0;
    store(16'h6000, 16'h5A5A, 2'b11, 1'b0);
    flush_only();
    checks++;
    if (pmem_write !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_drain wr=%b want 1", pmem_write);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (pmem_write !== 1'b0 || idle !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_drain wr=%b idle=%b want 0 1", pmem_write, idle);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    flush_only();
    repeat (3) begin
      checks++;
      if (pmem_write !== 1'b0 || idle !== 1'b1) begin
        errors++;
        $display("FAIL rst_no_write wr=%b idle=%b want 0 1", pmem_write, idle);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_flush_with_store();
    resp_en = 1'b1;
    store(16'h5000, 16'h7777, 2'b11, 1'b0);
    store(16'h5006, 16'h1234, 2'b11, 1'b1);
    wait_drains();
    checks++;
    if (last_wdata[63:48] !== 16'h1234 || (last_be & 16'h00C0) !== 16'h00C0 || last_addr !== 16'h5000) begin
      errors++;
      $display("FAIL flush_with_store w3=%h be=%h addr=%h want 1234 +00c0 5000",
               last_wdata[63:48], last_be, last_addr);
    end
  endtask

  task automatic test_random();
    logic [11:0] tags [3];
    logic [15:0] a;
    tags[0] = 12'h0A0; tags[1] = 12'h0A1; tags[2] = 12'h0B7;
    resp_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = {tags[$urandom_range(0, 2)], 3'($urandom_range(0, 7)), 1'b0};
      store(a, 16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 15) == 0) flush_only();
    end
    flush_only();
    wait_drains();
  endtask

  initial begin
    test_reset();
    test_single_flush();
    test_full_line();
    test_tag_conflict();
    test_byte_merge();
    test_reset_mid_drain();
    test_flush_with_store();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
